usb_host_pkt_tx: RTL and testbench

Parametrised host-side USB packet transmitter; successor to the fixed host send-packet engine.
- Sits between the host transaction scheduler and the SIE TX port arbiter.
- Serialises token, SOF, DATA and handshake packets into byte writes tagged with port control codes.
- Adds a programmable frame counter, a payload byte limit with overflow flag, and a configurable FIFO read latency.

---
 rtl/usb_host_pkt_tx.sv | 200 ++++++++++++++++++++
 tb/tb_usb_host_pkt_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_pkt_tx.sv
// rtl/usb_host_pkt_tx.sv - host USB packet transmitter; optional LS keep-alive via USB_HOST_LS_KEEPALIVE_EN
module usb_host_pkt_tx #(
  parameter int FRAME_W     = 11,
  parameter int MAX_PAYLOAD = 64,
  parameter int CNT_W       = 10,
  parameter int FIFO_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sendPacketWEn,
  output logic               sendPacketRdy,
  input  logic [3:0]         PID,
  input  logic [6:0]         TxAddr,
  input  logic [3:0]         TxEndP,
  input  logic               fullSpeedPolarity,
  input  logic               frameNumLoad,
  input  logic [FRAME_W-1:0] frameNumIn,
  output logic [FRAME_W-1:0] frameNum,
  input  logic [7:0]         fifoData,
  input  logic               fifoEmpty,
  output logic               fifoReadEn,
  output logic               HCTxPortReq,
  input  logic               HCTxPortGnt,
  input  logic               HCTxPortRdy,
  output logic               HCTxPortWEn,
  output logic [7:0]         HCTxPortData,
  output logic [7:0]         HCTxPortCntl,
  output logic [CNT_W-1:0]   payloadCnt,
  output logic               payloadOverflow
);

  localparam logic [7:0] CNTL_START = 8'h02;
  localparam logic [7:0] CNTL_DATA  = 8'h03;
  localparam logic [7:0] CNTL_STOP  = 8'h04;
`ifdef USB_HOST_LS_KEEPALIVE_EN
  localparam logic [7:0] CNTL_KEEP  = 8'h06;
`endif
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PAYLOAD);
  localparam logic [1:0]       LAT_C = 2'(FIFO_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_PIDB, S_TOK1, S_TOK2, S_SOF1, S_SOF2,
    S_DCHK, S_DRDY, S_DLAT, S_DWR, S_STOP, S_DONE
`ifdef USB_HOST_LS_KEEPALIVE_EN
    , S_KEEP
`endif
  } state_e;

  state_e     state_q;
  logic [3:0] pid_q;
  logic [6:0] addr_q;
  logic [3:0] endp_q;
  logic [1:0] lat_q;
  logic [7:0] data_q;
`ifdef USB_HOST_LS_KEEPALIVE_EN
  logic       fs_q;
`else
  logic       unused_fs;
  assign unused_fs = fullSpeedPolarity;
`endif

  logic   is_token, is_sof, is_data;
  logic   byte_st_d;
  logic [7:0] byte_d, cntl_d;
  state_e after_d;

  assign is_token = (pid_q == 4'h1) || (pid_q == 4'h9) || (pid_q == 4'hD);
  assign is_sof   = (pid_q == 4'h5);
  assign is_data  = (pid_q == 4'h3) || (pid_q == 4'hB);

  // Byte-emitting states: what to write and where to go once the strobe drops
  always_comb begin
    byte_st_d = 1'b1;
    byte_d    = 8'h00;
    cntl_d    = CNTL_DATA;
    after_d   = S_DONE;
    case (state_q)
      S_PIDB: begin
        byte_d = {~pid_q, pid_q};
        cntl_d = CNTL_START;
        if (is_token)    after_d = S_TOK1;
        else if (is_sof) after_d = S_SOF1;
        else if (is_data) after_d = S_DCHK;
        else             after_d = S_DONE;
      end
      S_TOK1: begin byte_d = {endp_q[0], addr_q};      after_d = S_TOK2; end
      S_TOK2: begin byte_d = {5'b0, endp_q[3:1]};     after_d = S_DONE; end
      S_SOF1: begin byte_d = frameNum[7:0];            after_d = S_SOF2; end
      S_SOF2: begin byte_d = {5'b0, frameNum[10:8]};  after_d = S_DONE; end
      S_DWR:  begin byte_d = data_q;                   after_d = S_DCHK; end
      S_STOP: begin cntl_d = CNTL_STOP;                after_d = S_DONE; end
`ifdef USB_HOST_LS_KEEPALIVE_EN
      S_KEEP: begin cntl_d = CNTL_KEEP;                after_d = S_DONE; end
`endif
      default: byte_st_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pid_q           <= 4'h0;
      addr_q          <= 7'h00;
      endp_q          <= 4'h0;
      lat_q           <= 2'd0;
      data_q          <= 8'h00;
`ifdef USB_HOST_LS_KEEPALIVE_EN
      fs_q            <= 1'b0;
`endif
      sendPacketRdy   <= 1'b1;
      frameNum        <= '0;
      fifoReadEn      <= 1'b0;
      HCTxPortReq     <= 1'b0;
      HCTxPortWEn     <= 1'b0;
      HCTxPortData    <= 8'h00;
      HCTxPortCntl    <= 8'h00;
      payloadCnt      <= '0;
      payloadOverflow <= 1'b0;
    end else begin
      // An explicit load wins over the end-of-SOF increment
      if (frameNumLoad)
        frameNum <= frameNumIn;
      else if (state_q == S_SOF2 && HCTxPortWEn)
        frameNum <= frameNum + 1'b1;

      if (byte_st_d) begin
        if (HCTxPortWEn) begin
          HCTxPortWEn <= 1'b0;
          state_q     <= after_d;
          if (state_q == S_DWR)
            payloadCnt <= payloadCnt + 1'b1;
        end else if (HCTxPortRdy) begin
          HCTxPortWEn  <= 1'b1;
          HCTxPortData <= byte_d;
          HCTxPortCntl <= cntl_d;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sendPacketWEn) begin
              pid_q           <= PID;
              addr_q          <= TxAddr;
              endp_q          <= TxEndP;
`ifdef USB_HOST_LS_KEEPALIVE_EN
              fs_q            <= fullSpeedPolarity;
`endif
              sendPacketRdy   <= 1'b0;
              HCTxPortReq     <= 1'b1;
              payloadCnt      <= '0;
              payloadOverflow <= 1'b0;
              state_q         <= S_REQ;
            end
          end
          S_REQ: begin
            if (HCTxPortGnt) begin
`ifdef USB_HOST_LS_KEEPALIVE_EN
              state_q <= (is_sof && !fs_q) ? S_KEEP : S_PIDB;
`else
              state_q <= S_PIDB;
`endif
            end
          end
          S_DCHK: begin
            if (!fifoEmpty && payloadCnt < MAX_C) begin
              state_q <= S_DRDY;
            end else begin
              if (!fifoEmpty)
                payloadOverflow <= 1'b1;
              state_q <= S_STOP;
            end
          end
          S_DRDY: begin
            if (HCTxPortRdy) begin
              fifoReadEn <= 1'b1;
              lat_q      <= 2'd0;
              state_q    <= S_DLAT;
            end
          end
          // lat_q counts cycles since the pop was presented to the FIFO
          S_DLAT: begin
            fifoReadEn <= 1'b0;
            if (lat_q == LAT_C) begin
              data_q  <= fifoData;
              state_q <= S_DWR;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          S_DONE: begin
            HCTxPortReq   <= 1'b0;
            sendPacketRdy <= 1'b1;
            state_q       <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_host_pkt_tx.sv
// tb/tb_usb_host_pkt_tx.sv - directed bench for usb_host_pkt_tx (FIFO_LAT 2, MAX_PAYLOAD 4)
module tb_usb_host_pkt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sendPacketWEn;
  logic        sendPacketRdy;
  logic [3:0]  PID;
  logic [6:0]  TxAddr;
  logic [3:0]  TxEndP;
  logic        fullSpeedPolarity;
  logic        frameNumLoad;
  logic [10:0] frameNumIn;
  logic [10:0] frameNum;
  logic [7:0]  fifoData = 8'h00;
  logic        fifoEmpty = 1'b1;
  logic        fifoReadEn;
  logic        HCTxPortReq;
  logic        HCTxPortGnt = 1'b0;
  logic        HCTxPortRdy = 1'b1;
  logic        HCTxPortWEn;
  logic [7:0]  HCTxPortData;
  logic [7:0]  HCTxPortCntl;
  logic [9:0]  payloadCnt;
  logic        payloadOverflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic rdy_toggle = 1'b0;
  logic [7:0]  fq[$];
  logic [7:0]  pipe = 8'h00;
  logic [15:0] wq[$];

  usb_host_pkt_tx #(.FRAME_W(11), .MAX_PAYLOAD(4), .CNT_W(10), .FIFO_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .sendPacketWEn(sendPacketWEn), .sendPacketRdy(sendPacketRdy),
    .PID(PID), .TxAddr(TxAddr), .TxEndP(TxEndP), .fullSpeedPolarity(fullSpeedPolarity),
    .frameNumLoad(frameNumLoad), .frameNumIn(frameNumIn), .frameNum(frameNum),
    .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoReadEn(fifoReadEn),
    .HCTxPortReq(HCTxPortReq), .HCTxPortGnt(HCTxPortGnt), .HCTxPortRdy(HCTxPortRdy),
    .HCTxPortWEn(HCTxPortWEn), .HCTxPortData(HCTxPortData), .HCTxPortCntl(HCTxPortCntl),
    .payloadCnt(payloadCnt), .payloadOverflow(payloadOverflow)
  );

  always #5 clk = ~clk;

  // SIE arbiter, 2-cycle-latency FIFO and write recorder
  always @(negedge clk) begin
    HCTxPortGnt = HCTxPortReq;
    HCTxPortRdy = rdy_toggle ? ~HCTxPortRdy : 1'b1;
    fifoData = pipe;
    if (fifoReadEn && fq.size() > 0) pipe = fq.pop_front();
    fifoEmpty = (fq.size() == 0);
    if (HCTxPortWEn) wq.push_back({HCTxPortCntl, HCTxPortData});
  end

  task automatic send_req(input logic [3:0] pid, input logic [6:0] addr,
                          input logic [3:0] endp, input logic fs);
    @(negedge clk);
    wq.delete();
    PID = pid; TxAddr = addr; TxEndP = endp; fullSpeedPolarity = fs;
    sendPacketWEn = 1'b1;
    @(negedge clk);
    sendPacketWEn = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sendPacketRdy === 1'b1) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_tests++; if (sendPacketRdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", sendPacketRdy); end
    n_tests++; if (frameNum !== 11'h000) begin n_fail++; $display("FAIL reset_frame: got %h expected 000", frameNum); end
    n_tests++; if (payloadCnt !== 10'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", payloadCnt); end
    n_tests++;
    if ({HCTxPortReq, HCTxPortWEn, fifoReadEn, payloadOverflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {HCTxPortReq, HCTxPortWEn, fifoReadEn, payloadOverflow});
    end
    n_tests++;
    if ({HCTxPortData, HCTxPortCntl} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0000", {HCTxPortData, HCTxPortCntl});
    end
  endtask

  task automatic test_token;
    logic [15:0] exp[$];
    bit to;
    exp = '{16'h0269, 16'h0395, 16'h0302};
    send_req(4'h9, 7'h15, 4'h5, 1'b1);
    PID = 4'h2; sendPacketWEn = 1'b1;     // must be ignored while busy
    @(negedge clk);
    sendPacketWEn = 1'b0;
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL token_timeout: got busy expected idle"); end
    n_tests++; if (HCTxPortReq !== 1'b0) begin n_fail++; $display("FAIL token_req: got %b expected 0", HCTxPortReq); end
    repeat (10) @(negedge clk);
    n_tests++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL token_len: got %0d expected %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      n_tests++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_fail++; $display("FAIL token_byte%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_sof_wrap;
    logic [15:0] exp[$];
    bit to;
    exp = '{16'h02A5, 16'h03FF, 16'h0307};
    @(negedge clk);
    frameNumLoad = 1'b1; frameNumIn = 11'h7FF;
    @(negedge clk);
    frameNumLoad = 1'b0;
    n_tests++; if (frameNum !== 11'h7FF) begin n_fail++; $display("FAIL sof_load: got %h expected 7ff", frameNum); end
    send_req(4'h5, 7'h00, 4'h0, 1'b1);
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL sof_timeout: got busy expected idle"); end
    n_tests++; if (frameNum !== 11'h000) begin n_fail++; $display("FAIL sof_wrap: got %h expected 000", frameNum); end
    n_tests++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL sof_len: got %0d expected %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      n_tests++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_fail++; $display("FAIL sof_byte%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_data;
    logic [15:0] exp[$];
    bit to;
    exp = '{16'h02C3, 16'h0311, 16'h0322, 16'h0333, 16'h0400};
    fq = '{8'h11, 8'h22, 8'h33};
    rdy_toggle = 1'b1;
    send_req(4'h3, 7'h01, 4'h1, 1'b1);
    wait_idle(to);
    rdy_toggle = 1'b0;
    n_tests++; if (to) begin n_fail++; $display("FAIL data_timeout: got busy expected idle"); end
    n_tests++; if (payloadCnt !== 10'd3) begin n_fail++; $display("FAIL data_cnt: got %0d expected 3", payloadCnt); end
    n_tests++; if (payloadOverflow !== 1'b0) begin n_fail++; $display("FAIL data_ovf: got %b expected 0", payloadOverflow); end
    n_tests++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL data_len: got %0d expected %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      n_tests++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_fail++; $display("FAIL data_byte%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] exp[$];
    bit to;
    exp = '{16'h024B, 16'h03A1, 16'h03A2, 16'h03A3, 16'h03A4, 16'h0400};
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_req(4'hB, 7'h02, 4'h2, 1'b1);
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ovf_timeout: got busy expected idle"); end
    n_tests++; if (payloadOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", payloadOverflow); end
    n_tests++; if (payloadCnt !== 10'd4) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 4", payloadCnt); end
    n_tests++; if (fq.size() != 2) begin n_fail++; $display("FAIL ovf_fifo_left: got %0d expected 2", fq.size()); end
    n_tests++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL ovf_len: got %0d expected %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      n_tests++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
      end
    end
    fq.delete();
  endtask

  task automatic test_handshake;
    bit to;
    send_req(4'h2, 7'h00, 4'h0, 1'b1);
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL hs_timeout: got busy expected idle"); end
    n_tests++; if (payloadOverflow !== 1'b0) begin n_fail++; $display("FAIL hs_ovf_clear: got %b expected 0", payloadOverflow); end
    n_tests++; if (payloadCnt !== 10'd0) begin n_fail++; $display("FAIL hs_cnt_clear: got %0d expected 0", payloadCnt); end
    n_tests++; if (wq.size() != 1) begin n_fail++; $display("FAIL hs_len: got %0d expected 1", wq.size()); end
    n_tests++; if (wq.size() < 1 || wq[0] !== 16'h02D2) begin n_fail++; $display("FAIL hs_byte: got %h expected 02d2", (wq.size() > 0) ? wq[0] : 16'hxxxx); end
  endtask

  task automatic test_keepalive;
    logic [15:0] exp[$];
    logic [10:0] exp_frame;
    bit to;
`ifdef USB_HOST_LS_KEEPALIVE_EN
    exp = '{16'h0600};
    exp_frame = 11'h000;
`else
    exp = '{16'h02A5, 16'h0300, 16'h0300};
    exp_frame = 11'h001;
`endif
    send_req(4'h5, 7'h00, 4'h0, 1'b0);
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ka_timeout: got busy expected idle"); end
    n_tests++; if (frameNum !== exp_frame) begin n_fail++; $display("FAIL ka_frame: got %h expected %h", frameNum, exp_frame); end
    n_tests++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL ka_len: got %0d expected %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      n_tests++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        n_fail++; $display("FAIL ka_byte%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_frame_load;
    int  pulses = 0;
    bit  hit = 1'b0;
    bit  to;
    send_req(4'h5, 7'h00, 4'h0, 1'b1);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (HCTxPortWEn === 1'b1) pulses++;
      if (pulses == 3 && HCTxPortWEn === 1'b1) begin
        hit = 1'b1;
        frameNumLoad = 1'b1; frameNumIn = 11'h123;
        @(negedge clk);
        frameNumLoad = 1'b0;
        n_tests++; if (frameNum !== 11'h123) begin n_fail++; $display("FAIL fload_prio: got %h expected 123", frameNum); end
      end else begin
        @(negedge clk);
      end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL fload_timeout: got %0d writes expected 3", pulses); end
    wait_idle(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL fload_idle: got busy expected idle"); end
    n_tests++; if (frameNum !== 11'h123) begin n_fail++; $display("FAIL fload_hold: got %h expected 123", frameNum); end
  endtask

  task automatic test_reset_mid;
    bit hit = 1'b0;
    int nw;
    fq = '{8'h55, 8'h66, 8'h77};
    send_req(4'h3, 7'h03, 4'h3, 1'b1);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (wq.size() >= 2) hit = 1'b1;
      else @(negedge clk);
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rmid_timeout: got %0d writes expected 2", wq.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (sendPacketRdy !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy: got %b expected 1", sendPacketRdy); end
    n_tests++; if (HCTxPortWEn !== 1'b0) begin n_fail++; $display("FAIL rmid_wen: got %b expected 0", HCTxPortWEn); end
    n_tests++; if (HCTxPortReq !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b expected 0", HCTxPortReq); end
    nw = wq.size();
    repeat (30) @(negedge clk);
    n_tests++; if (wq.size() != nw) begin n_fail++; $display("FAIL rmid_no_stop: got %0d writes expected %0d", wq.size(), nw); end
    fq.delete();
  endtask

  initial begin
    rst = 1'b1;
    sendPacketWEn = 1'b0; PID = 4'h0; TxAddr = 7'h00; TxEndP = 4'h0;
    fullSpeedPolarity = 1'b1; frameNumLoad = 1'b0; frameNumIn = 11'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_token;
    test_sof_wrap;
    test_data;
    test_overflow;
    test_handshake;
    test_keepalive;
    test_frame_load;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
